// File: rtl/soml_if.sv
// Frame-input and result bundle for the SOML detector.
// The master side streams H/Y beats and receives the decision; the slave side is the detector.
interface soml_if #(
    parameter int N = 32
);
    logic         start;
    logic         H_in_valid;
    logic [N-1:0] H_in_r;
    logic [N-1:0] H_in_i;
    logic         Y_in_valid;
    logic [N-1:0] Y_in_r;
    logic [N-1:0] Y_in_i;
    logic         output_valid;
    logic [N-1:0] s_I_1;
    logic [N-1:0] s_Q_1;
    logic [N-1:0] s_I_2;
    logic [N-1:0] s_Q_2;
    logic [4:0]   Smin_index;
    logic [11:0]  signal_out_12bit;

    modport master (
        output start, H_in_valid, H_in_r, H_in_i, Y_in_valid, Y_in_r, Y_in_i,
        input  output_valid, s_I_1, s_Q_1, s_I_2, s_Q_2, Smin_index, signal_out_12bit
    );

    modport slave (
        input  start, H_in_valid, H_in_r, H_in_i, Y_in_valid, Y_in_r, Y_in_i,
        output output_valid, s_I_1, s_Q_1, s_I_2, s_Q_2, Smin_index, signal_out_12bit
    );
endinterface

// File: rtl/soml_decoder.sv
// Sub-optimal ML detector for a 4x4 MIMO link carrying two 16-QAM symbols over two slots.
// Loads H (4x4) and Y (4x2), forms per-column matched-filter terms, then scans 16 column pairings.
module soml_decoder #(
    parameter int N = 32,
    parameter int Q = 22
) (
    input  logic   clk,
    input  logic   rst,
    soml_if.slave  bus
);
    localparam int PW  = 2 * N;
    localparam int SW  = 2 * N + 3;
    localparam int XW  = SW + 2;
    localparam int MW  = 2 * N + 6;
    localparam int MSW = MW + 1;

    localparam logic signed [2:0] LVL_P3 = 3'sd3;
    localparam logic signed [2:0] LVL_P1 = 3'sd1;
    localparam logic signed [2:0] LVL_M1 = -3'sd1;
    localparam logic signed [2:0] LVL_M3 = -3'sd3;

    typedef enum logic [2:0] {IDLE, LOAD, CALC, SEARCH, DONE} state_t;
    state_t state, state_next;

    logic signed [N-1:0] h_r [16];
    logic signed [N-1:0] h_i [16];
    logic signed [N-1:0] y_r [8];
    logic signed [N-1:0] y_i [8];

    logic [4:0] h_cnt;
    logic [3:0] y_cnt;
    logic [1:0] calc_cnt;
    logic [3:0] search_cnt;
    logic       h_take, y_take, h_done, y_done;

    logic signed [SW-1:0] g_q  [4];
    logic signed [SW-1:0] zr_q [4][2];
    logic signed [SW-1:0] zi_q [4][2];
    logic signed [SW-1:0] g_sum;
    logic signed [SW-1:0] zr_sum [2];
    logic signed [SW-1:0] zi_sum [2];
    logic signed [N-1:0]  hr, hi, yr, yi;

    logic [1:0]            c1, c2;
    logic signed [2:0]     li1, lq1, li2, lq2;
    logic signed [MSW-1:0] m_sum, best_metric;
    logic [3:0]            best_q;
    logic signed [2:0]     best_li1, best_lq1, best_li2, best_lq2;

    function automatic logic signed [SW-1:0] mul_ext(input logic signed [N-1:0] a,
                                                     input logic signed [N-1:0] b);
        return SW'(PW'(a) * PW'(b));
    endfunction

    function automatic logic is_three(input logic [2:0] l);
        return (l == 3'b011) || (l == 3'b101);
    endfunction

    function automatic logic signed [2:0] slice(input logic signed [SW-1:0] x,
                                                input logic signed [SW-1:0] g);
        logic signed [XW-1:0] xe, two_g;
        xe    = XW'(x);
        two_g = XW'(g) <<< 1;
        if (xe > two_g)       return LVL_P3;
        else if (!xe[XW-1])   return LVL_P1;
        else if (xe >= -two_g) return LVL_M1;
        else                  return LVL_M3;
    endfunction

    function automatic logic signed [MW-1:0] scale(input logic signed [MW-1:0] x,
                                                   input logic signed [2:0] l);
        logic signed [MW-1:0] mag;
        mag = is_three(l) ? x + (x <<< 1) : x;
        return l[2] ? -mag : mag;
    endfunction

    // g*(sI^2+sQ^2) only takes the values 2g, 10g or 18g, so it is built from shifts.
    function automatic logic signed [MW-1:0] metric(input logic signed [SW-1:0] g,
                                                    input logic signed [SW-1:0] zr,
                                                    input logic signed [SW-1:0] zi,
                                                    input logic signed [2:0] li,
                                                    input logic signed [2:0] lq);
        logic signed [MW-1:0] gw, energy, corr;
        gw = MW'(g);
        case ({is_three(li), is_three(lq)})
            2'b00:   energy = gw <<< 1;
            2'b11:   energy = (gw <<< 4) + (gw <<< 1);
            default: energy = (gw <<< 3) + (gw <<< 1);
        endcase
        corr = scale(MW'(zr), li) + scale(MW'(zi), lq);
        return energy - (corr <<< 1);
    endfunction

    function automatic logic [1:0] gray(input logic signed [2:0] l);
        case (l)
            LVL_P3:  return 2'b10;
            LVL_P1:  return 2'b11;
            LVL_M1:  return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    assign h_take = (state == LOAD) && bus.H_in_valid && (h_cnt != 5'd16);
    assign y_take = (state == LOAD) && bus.Y_in_valid && (y_cnt != 4'd8);
    assign h_done = (h_cnt == 5'd16) || (h_take && (h_cnt == 5'd15));
    assign y_done = (y_cnt == 4'd8)  || (y_take && (y_cnt == 4'd7));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = LOAD;
            LOAD:    if (h_done && y_done) state_next = CALC;
            CALC:    if (calc_cnt == 2'd3) state_next = SEARCH;
            SEARCH:  if (search_cnt == 4'd15) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The H and Y streams advance independently; each stops accepting once full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            y_cnt <= '0;
            for (int k = 0; k < 16; k++) begin
                h_r[k] <= '0;
                h_i[k] <= '0;
            end
            for (int k = 0; k < 8; k++) begin
                y_r[k] <= '0;
                y_i[k] <= '0;
            end
        end else begin
            if (state == IDLE && bus.start) begin
                h_cnt <= '0;
                y_cnt <= '0;
            end
            if (h_take) begin
                h_r[h_cnt[3:0]] <= bus.H_in_r;
                h_i[h_cnt[3:0]] <= bus.H_in_i;
                h_cnt           <= h_cnt + 5'd1;
            end
            if (y_take) begin
                y_r[y_cnt[2:0]] <= bus.Y_in_r;
                y_i[y_cnt[2:0]] <= bus.Y_in_i;
                y_cnt           <= y_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            calc_cnt   <= '0;
            search_cnt <= '0;
        end else begin
            calc_cnt   <= (state == CALC)   ? calc_cnt + 2'd1   : 2'd0;
            search_cnt <= (state == SEARCH) ? search_cnt + 4'd1 : 4'd0;
        end
    end

    // One tx column per CALC cycle: energy g and conj(H)^T * Y for both slots, full precision.
    always_comb begin
        g_sum     = '0;
        zr_sum[0] = '0;
        zr_sum[1] = '0;
        zi_sum[0] = '0;
        zi_sum[1] = '0;
        hr = '0;
        hi = '0;
        yr = '0;
        yi = '0;
        for (int r = 0; r < 4; r++) begin
            hr    = h_r[{2'(r), calc_cnt}];
            hi    = h_i[{2'(r), calc_cnt}];
            g_sum = g_sum + mul_ext(hr, hr) + mul_ext(hi, hi);
            for (int t = 0; t < 2; t++) begin
                yr = y_r[{2'(r), 1'(t)}];
                yi = y_i[{2'(r), 1'(t)}];
                zr_sum[1'(t)] = zr_sum[1'(t)] + mul_ext(hr, yr) + mul_ext(hi, yi);
                zi_sum[1'(t)] = zi_sum[1'(t)] + mul_ext(hr, yi) - mul_ext(hi, yr);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < 4; c++) begin
                g_q[c] <= '0;
                for (int t = 0; t < 2; t++) begin
                    zr_q[c][t] <= '0;
                    zi_q[c][t] <= '0;
                end
            end
        end else if (state == CALC) begin
            g_q[calc_cnt]     <= g_sum;
            zr_q[calc_cnt][0] <= zr_sum[0];
            zr_q[calc_cnt][1] <= zr_sum[1];
            zi_q[calc_cnt][0] <= zi_sum[0];
            zi_q[calc_cnt][1] <= zi_sum[1];
        end
    end

    assign c1 = search_cnt[3:2];
    assign c2 = search_cnt[1:0];

    always_comb begin
        li1   = slice(zr_q[c1][0], g_q[c1]);
        lq1   = slice(zi_q[c1][0], g_q[c1]);
        li2   = slice(zr_q[c2][1], g_q[c2]);
        lq2   = slice(zi_q[c2][1], g_q[c2]);
        m_sum = MSW'(metric(g_q[c1], zr_q[c1][0], zi_q[c1][0], li1, lq1))
              + MSW'(metric(g_q[c2], zr_q[c2][1], zi_q[c2][1], li2, lq2));
    end

    // Strict less-than keeps the lowest candidate index on ties.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_metric <= '0;
            best_q      <= '0;
            best_li1    <= '0;
            best_lq1    <= '0;
            best_li2    <= '0;
            best_lq2    <= '0;
        end else if (state == SEARCH && (search_cnt == 4'd0 || m_sum < best_metric)) begin
            best_metric <= m_sum;
            best_q      <= search_cnt;
            best_li1    <= li1;
            best_lq1    <= lq1;
            best_li2    <= li2;
            best_lq2    <= lq2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.output_valid     <= 1'b0;
            bus.s_I_1            <= '0;
            bus.s_Q_1            <= '0;
            bus.s_I_2            <= '0;
            bus.s_Q_2            <= '0;
            bus.Smin_index       <= '0;
            bus.signal_out_12bit <= '0;
        end else begin
            bus.output_valid <= (state == DONE);
            if (state == DONE) begin
                bus.s_I_1            <= N'(best_li1) <<< Q;
                bus.s_Q_1            <= N'(best_lq1) <<< Q;
                bus.s_I_2            <= N'(best_li2) <<< Q;
                bus.s_Q_2            <= N'(best_lq2) <<< Q;
                bus.Smin_index       <= {1'b0, best_q};
                bus.signal_out_12bit <= {best_q, gray(best_li1), gray(best_lq1),
                                         gray(best_li2), gray(best_lq2)};
            end
        end
    end
endmodule

// File: tb/tb_soml_decoder.sv
// Directed bench for soml_decoder: table of frames with hand-computed decisions,
// plus idle-beat, mid-load reset and start-during-search sequences.
module tb_soml_decoder;
    localparam int N     = 32;
    localparam int Q     = 22;
    localparam int ONE   = 1 << Q;
    localparam int NOISE = 838861;

    logic clk = 1'b0;
    logic rst;

    soml_if #(.N(N)) bus ();

    soml_decoder #(.N(N), .Q(Q)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          id_h;
        bit          noise;
        logic [3:0]  pos;
        int          yi1, yq1, yi2, yq2;
        int          mode;
        bit          inject;
        logic [4:0]  exp_idx;
        logic [11:0] exp_bits;
        int          ei1, eq1, ei2, eq2;
    } vec_t;

    vec_t vecs [14];

    logic [N-1:0] frame_hr [16];
    logic [N-1:0] frame_hi [16];
    logic [N-1:0] frame_yr [8];
    logic [N-1:0] frame_yi [8];

    function automatic vec_t make_vec(input bit id_h, input bit noise, input logic [3:0] pos,
                                      input int yi1, input int yq1, input int yi2, input int yq2,
                                      input int mode, input bit inject,
                                      input logic [4:0] exp_idx, input logic [11:0] exp_bits,
                                      input int ei1, input int eq1, input int ei2, input int eq2);
        vec_t v;
        v.id_h = id_h; v.noise = noise; v.pos = pos;
        v.yi1 = yi1; v.yq1 = yq1; v.yi2 = yi2; v.yq2 = yq2;
        v.mode = mode; v.inject = inject;
        v.exp_idx = exp_idx; v.exp_bits = exp_bits;
        v.ei1 = ei1; v.eq1 = eq1; v.ei2 = ei2; v.eq2 = eq2;
        return v;
    endfunction

    function automatic logic [N-1:0] lvl(input int l);
        return N'(l * ONE);
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic fill_frame(input vec_t v);
        logic [2:0] idx0, idx1;
        int nz;
        for (int k = 0; k < 16; k++) begin
            frame_hr[4'(k)] = (v.id_h && (k / 4 == k % 4)) ? N'(ONE) : '0;
            frame_hi[4'(k)] = '0;
        end
        for (int k = 0; k < 8; k++) begin
            frame_yr[3'(k)] = '0;
            frame_yi[3'(k)] = '0;
        end
        if (v.id_h) begin
            idx0 = {v.pos[3:2], 1'b0};
            idx1 = {v.pos[1:0], 1'b1};
            frame_yr[idx0] = N'(v.yi1 * ONE);
            frame_yi[idx0] = N'(v.yq1 * ONE);
            frame_yr[idx1] = N'(v.yi2 * ONE);
            frame_yi[idx1] = N'(v.yq2 * ONE);
        end
        if (v.noise) begin
            for (int k = 0; k < 8; k++) begin
                nz = (k % 2 == 0) ? NOISE : -NOISE;
                frame_yr[3'(k)] = frame_yr[3'(k)] + N'(nz);
                frame_yi[3'(k)] = frame_yi[3'(k)] - N'(nz);
            end
        end
    endtask

    task automatic clear_inputs();
        bus.H_in_valid = 1'b0;
        bus.Y_in_valid = 1'b0;
        bus.H_in_r = '0;
        bus.H_in_i = '0;
        bus.Y_in_r = '0;
        bus.Y_in_i = '0;
    endtask

    // Drives beats with no start pulse and counts any output_valid that appears.
    task automatic drive_without_start(output int pulses);
        pulses = 0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            @(negedge clk);
            bus.H_in_valid = (cyc < 24);
            bus.Y_in_valid = (cyc < 24);
            bus.H_in_r = N'(cyc * ONE);
            bus.H_in_i = N'(-cyc * ONE);
            bus.Y_in_r = N'(3 * ONE);
            bus.Y_in_i = N'(-ONE);
            @(posedge clk);
            #1;
            if (bus.output_valid) pulses++;
        end
        clear_inputs();
    endtask

    task automatic apply_stimulus(input int id, input vec_t v);
        int  ncyc, hk, yk, lat;
        bit  yv, got;
        fill_frame(v);
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        ncyc = (v.mode == 2) ? 20 : 16;
        hk = 0;
        yk = 0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge clk);
            case (v.mode)
                0:       yv = (cyc < 8);
                1:       yv = (cyc % 2 == 1);
                default: yv = (cyc >= 12);
            endcase
            bus.H_in_valid = 1'b1;
            if (hk < 16) begin
                bus.H_in_r = frame_hr[4'(hk)];
                bus.H_in_i = frame_hi[4'(hk)];
            end else begin
                bus.H_in_r = 32'h7FFF_FFFF;
                bus.H_in_i = 32'h8000_0001;
            end
            hk++;
            bus.Y_in_valid = yv;
            if (yv) begin
                bus.Y_in_r = frame_yr[3'(yk)];
                bus.Y_in_i = frame_yi[3'(yk)];
                yk++;
            end else begin
                bus.Y_in_r = 32'h1234_5678;
                bus.Y_in_i = 32'h8765_4321;
            end
        end
        @(posedge clk);
        #1;
        clear_inputs();
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (v.inject && lat == 10)      bus.start = 1'b1;
            else if (v.inject && lat == 11) bus.start = 1'b0;
            got = bus.output_valid;
        end
        bus.start = 1'b0;
        check_output($sformatf("f%0d_latency", id), 64'(lat), 64'd21);
        check_output($sformatf("f%0d_index", id), 64'(bus.Smin_index), 64'(v.exp_idx));
        check_output($sformatf("f%0d_bits", id), 64'(bus.signal_out_12bit), 64'(v.exp_bits));
        check_output($sformatf("f%0d_s_I_1", id), 64'(bus.s_I_1), 64'(lvl(v.ei1)));
        check_output($sformatf("f%0d_s_Q_1", id), 64'(bus.s_Q_1), 64'(lvl(v.eq1)));
        check_output($sformatf("f%0d_s_I_2", id), 64'(bus.s_I_2), 64'(lvl(v.ei2)));
        check_output($sformatf("f%0d_s_Q_2", id), 64'(bus.s_Q_2), 64'(lvl(v.eq2)));
        @(posedge clk);
        #1;
        check_output($sformatf("f%0d_pulse_end", id), 64'(bus.output_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check_output($sformatf("f%0d_hold_bits", id), 64'(bus.signal_out_12bit), 64'(v.exp_bits));
        check_output($sformatf("f%0d_hold_s_Q_2", id), 64'(bus.s_Q_2), 64'(lvl(v.eq2)));
    endtask

    initial begin
        int pulses;

        vecs[0]  = make_vec(0, 0, 4'd0,   0,  0,  0,  0, 0, 0, 5'd0,  12'b0000_11_11_11_11,  1,  1,  1,  1);
        vecs[1]  = make_vec(1, 0, 4'd9,   3, -1, -1,  3, 1, 0, 5'd9,  12'b1001_10_01_01_10,  3, -1, -1,  3);
        vecs[2]  = make_vec(1, 1, 4'd9,   3, -1, -1,  3, 2, 0, 5'd9,  12'b1001_10_01_01_10,  3, -1, -1,  3);
        vecs[3]  = make_vec(1, 0, 4'd9,   3, -1, -1,  3, 0, 0, 5'd9,  12'b1001_10_01_01_10,  3, -1, -1,  3);
        vecs[4]  = make_vec(1, 0, 4'd0,   1,  1,  1,  1, 1, 0, 5'd0,  12'b0000_11_11_11_11,  1,  1,  1,  1);
        vecs[5]  = make_vec(1, 0, 4'd15, -3, -3,  3,  3, 2, 0, 5'd15, 12'b1111_00_00_10_10, -3, -3,  3,  3);
        vecs[6]  = make_vec(1, 0, 4'd6,   3,  3, -3, -1, 0, 0, 5'd6,  12'b0110_10_10_00_01,  3,  3, -3, -1);
        vecs[7]  = make_vec(1, 0, 4'd4,  -1,  1,  1, -3, 1, 1, 5'd4,  12'b0100_01_11_11_00, -1,  1,  1, -3);
        vecs[8]  = make_vec(1, 0, 4'd11,  1, -3, -1, -1, 2, 0, 5'd11, 12'b1011_11_00_01_01,  1, -3, -1, -1);
        vecs[9]  = make_vec(1, 0, 4'd2,  -3,  1,  3, -1, 0, 0, 5'd2,  12'b0010_00_11_10_01, -3,  1,  3, -1);
        vecs[10] = make_vec(1, 0, 4'd13,  3, -3,  1,  3, 1, 0, 5'd13, 12'b1101_10_00_11_10,  3, -3,  1,  3);
        vecs[11] = make_vec(1, 0, 4'd7,  -1, -1, -3,  1, 2, 0, 5'd7,  12'b0111_01_01_00_11, -1, -1, -3,  1);
        vecs[12] = make_vec(1, 0, 4'd12,  1,  3, -1, -3, 0, 0, 5'd12, 12'b1100_11_10_01_00,  1,  3, -1, -3);
        // Components sitting exactly on +-2g must slice to +-1, not +-3.
        vecs[13] = make_vec(1, 0, 4'd5,   2, -2, -2,  2, 1, 0, 5'd5,  12'b0101_11_01_01_11,  1, -1, -1,  1);

        rst = 1'b0;
        bus.start = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_valid", 64'(bus.output_valid), 64'd0);
        check_output("reset_index", 64'(bus.Smin_index), 64'd0);
        check_output("reset_bits", 64'(bus.signal_out_12bit), 64'd0);
        check_output("reset_s_I_1", 64'(bus.s_I_1), 64'd0);
        check_output("reset_s_Q_1", 64'(bus.s_Q_1), 64'd0);
        check_output("reset_s_I_2", 64'(bus.s_I_2), 64'd0);
        check_output("reset_s_Q_2", 64'(bus.s_Q_2), 64'd0);
        @(negedge clk) rst = 1'b1;

        drive_without_start(pulses);
        check_output("idle_no_valid", 64'(pulses), 64'd0);
        check_output("idle_bits", 64'(bus.signal_out_12bit), 64'd0);
        check_output("idle_s_I_1", 64'(bus.s_I_1), 64'd0);

        for (int i = 0; i < 14; i++) begin
            apply_stimulus(i, vecs[i]);
        end

        $display("[TB] reset during LOAD");
        fill_frame(vecs[5]);
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            bus.H_in_valid = 1'b1;
            bus.H_in_r = frame_hr[4'(cyc)];
            bus.H_in_i = frame_hi[4'(cyc)];
            bus.Y_in_valid = 1'b1;
            bus.Y_in_r = frame_yr[3'(cyc)];
            bus.Y_in_i = frame_yi[3'(cyc)];
        end
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        #1;
        check_output("rst_valid", 64'(bus.output_valid), 64'd0);
        check_output("rst_index", 64'(bus.Smin_index), 64'd0);
        check_output("rst_bits", 64'(bus.signal_out_12bit), 64'd0);
        check_output("rst_s_I_1", 64'(bus.s_I_1), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        drive_without_start(pulses);
        check_output("abort_no_valid", 64'(pulses), 64'd0);
        apply_stimulus(100, vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
